// File: rtl/dsp_pkg.sv
// Shared definitions for the sample-source front end: FSM states, default frame geometry, parameter legality.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int CLK_DIV_DEF = 250;
  localparam int FS_RISE_DEF = 125;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    WAIT
  } frame_state_e;

  // The conversion (CS setup, shift, CS hold) has to fit before f_s rises.
  // f_s must also stay high for at least two cycles.
  function automatic bit frame_params_legal(input int clk_div, input int fs_rise,
                                            input int sclk_div, input int data_w);
    return (sclk_div >= 1) && (data_w >= 2) &&
           (3 + 2 * sclk_div * data_w <= fs_rise) &&
           (fs_rise <= clk_div - 2);
  endfunction

endpackage

// File: rtl/adc_spi_rx.sv
// Serial ADC receiver: generates sclk, counts bits and shifts in adc_sdo MSB first after a start pulse.
// Latency: done asserts 2*SCLK_DIV*DATA_W cycles after start; word is valid combinationally alongside done.
// Backpressure: none; the transfer runs to completion once started (only reset aborts it).
//
// Ports: clk, rst (sync active-low), start (1-cycle pulse), sdo (ADC data),
//        sclk (serial clock, idles low), done (last-bit sample cycle), word (assembled sample).
module adc_spi_rx #(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sdo,
  output logic              sclk,
  output logic              done,
  output logic [DATA_W-1:0] word
);

  localparam int PH_W  = $clog2(2 * SCLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(SCLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic              active, active_n;
  logic [PH_W-1:0]   ph, ph_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-2:0] sh_q;
  logic              sample;

  // The clock edge that ends the sclk high phase samples sdo.
  assign sample = active && (ph == PH_LAST);
  assign done   = sample && (bit_cnt == BIT_LAST);
  // The value the shift register takes on a sampling edge.
  // At done this is the complete word, so the caller can capture it on the same edge.
  assign word   = {sh_q, sdo};

  always_comb begin
    active_n  = active;
    ph_n      = ph;
    bit_cnt_n = bit_cnt;
    if (start) begin
      active_n  = 1'b1;
      ph_n      = '0;
      bit_cnt_n = '0;
    end else if (active) begin
      if (sample) begin
        ph_n      = '0;
        bit_cnt_n = bit_cnt + BIT_W'(1);
        if (done) active_n = 1'b0;
      end else begin
        ph_n = ph + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= 1'b0;
      ph      <= '0;
      bit_cnt <= '0;
      sh_q    <= '0;
      sclk    <= 1'b0;
    end else begin
      active  <= active_n;
      ph      <= ph_n;
      bit_cnt <= bit_cnt_n;
      // sclk is registered from next-state phase so it is glitch-free.
      // Low for the first half of each bit, high for the second half.
      sclk    <= active_n && (ph_n >= PH_HIGH);
      if (sample) sh_q <= word[DATA_W-2:0];
    end
  end

endmodule

// File: rtl/adc_frame_src.sv
// Frame-rate sample source: divides clk into frames, reads one ADC word per frame, presents it with f_s.
// Latency: din and f_s rise together at frame cycle FS_RISE; the last ADC bit arrives at cycle 1+2*SCLK_DIV*DATA_W.
// Backpressure: none; free-running producer, so consumers must keep up with f_s.
//
// Ports: clk, rst (sync active-low), en (run enable), adc_sdo / adc_cs_n / adc_sclk (serial ADC),
//        f_s (frame strobe), din (signed sample), busy (= ~adc_cs_n).
module adc_frame_src
  import dsp_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int FS_RISE    = FS_RISE_DEF,
  parameter int SCLK_DIV   = 2,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OFFSET_BIN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     adc_sdo,
  output logic                     adc_cs_n,
  output logic                     adc_sclk,
  output logic                     f_s,
  output logic signed [DATA_W-1:0] din,
  output logic                     busy
);

  if (!frame_params_legal(CLK_DIV, FS_RISE, SCLK_DIV, DATA_W)) begin : g_param_check
    $error("adc_frame_src: illegal CLK_DIV/FS_RISE/SCLK_DIV/DATA_W combination");
  end

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE_M1 = CNT_W'(FS_RISE - 1);

  frame_state_e             state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic                     cs_n_n, fs_n, spi_start, spi_done;
  logic signed [DATA_W-1:0] din_n;
  logic [DATA_W-1:0]        pending, pending_n, spi_word;

  function automatic logic [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] raw);
    if (OFFSET_BIN != 0) return {~raw[DATA_W-1], raw[DATA_W-2:0]};
    return raw;
  endfunction

  adc_spi_rx #(
    .DATA_W   (DATA_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_spi (
    .clk   (clk),
    .rst   (rst),
    .start (spi_start),
    .sdo   (adc_sdo),
    .sclk  (adc_sclk),
    .done  (spi_done),
    .word  (spi_word)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    spi_start = 1'b0;
    pending_n = pending;
    fs_n      = f_s;
    din_n     = din;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (en) begin
          state_n = CS_SETUP;
          cnt_n   = CNT_W'(1);
        end
      end
      CS_SETUP: begin
        spi_start = 1'b1;
        state_n   = SHIFT;
        cnt_n     = cnt + CNT_W'(1);
      end
      SHIFT: begin
        cnt_n = cnt + CNT_W'(1);
        // Capture on the last sampling edge so pending is ready during CS_HOLD.
        // This lets FS_RISE be as early as one cycle after CS_HOLD.
        if (spi_done) begin
          state_n   = CS_HOLD;
          pending_n = to_twos(spi_word);
        end
      end
      CS_HOLD: begin
        state_n = WAIT;
        cnt_n   = cnt + CNT_W'(1);
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // CS_HOLD is included because at the minimum legal FS_RISE the rise is scheduled from there.
    if (((state == CS_HOLD) || (state == WAIT)) && (cnt == CNT_RISE_M1)) begin
      fs_n  = 1'b1;
      din_n = pending;
    end
    if ((state == WAIT) && (cnt == CNT_LAST)) fs_n = 1'b0;

    cs_n_n = !((state_n == CS_SETUP) || (state_n == SHIFT));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      adc_cs_n <= 1'b1;
      f_s      <= 1'b0;
      din      <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pending_n;
      adc_cs_n <= cs_n_n;
      f_s      <= fs_n;
      din      <= din_n;
    end
  end

  assign busy = ~adc_cs_n;

endmodule

// File: tb/tb_adc_frame_src.sv
// Bench for adc_frame_src: offset-binary and two's-complement instances in lockstep fed by one serial ADC model.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_frame_src;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic adc_sdo = 1'b0;

  logic        cs_n0, sclk0, f_s0, busy0;
  logic        cs_n1, sclk1, f_s1, busy1;
  logic [15:0] din0, din1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [15:0] adc_word = 16'h0000;
  logic [15:0] adc_sh   = 16'h0000;
  logic [15:0] sb[$];

  logic        mon_on = 1'b0;
  logic        b2b    = 1'b0;
  logic        fs_prev = 1'b0;
  logic [15:0] din0_prev = 16'h0000;
  int          last_rise = 0;
  int          last_gap  = 0;
  int          rises     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_frame_src #(.OFFSET_BIN(1)) dut_ob (
    .clk(clk), .rst(rst), .en(en), .adc_sdo(adc_sdo),
    .adc_cs_n(cs_n0), .adc_sclk(sclk0), .f_s(f_s0), .din(din0), .busy(busy0)
  );

  adc_frame_src #(.OFFSET_BIN(0)) dut_tc (
    .clk(clk), .rst(rst), .en(en), .adc_sdo(adc_sdo),
    .adc_cs_n(cs_n1), .adc_sclk(sclk1), .f_s(f_s1), .din(din1), .busy(busy1)
  );

  // Serial ADC model: loads its word when CS falls and presents the MSB first.
  // It moves to the next bit shortly after each sclk falling edge.
  always begin
    @(negedge cs_n0);
    #2;
    adc_sh  = adc_word;
    adc_sdo = adc_sh[15];
  end
  always begin
    @(negedge sclk0);
    #2;
    adc_sh  = {adc_sh[14:0], 1'b0};
    adc_sdo = adc_sh[15];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and timing monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0] w;
    if (f_s0 && !fs_prev) begin
      rises++;
      last_gap  = cyc - last_rise;
      last_rise = cyc;
      if (b2b) check("fs_rise_gap", last_gap, 250);
      check("sb_has_entry", {31'b0, sb.size() > 0}, 1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check("din_offset_bin", din0, {~w[15], w[14:0]});
        check("din_twos", din1, w);
      end
    end
    if (mon_on && (din0 !== din0_prev))
      check("din_change_on_fs_rise", {31'b0, f_s0 && !fs_prev}, 1);
    fs_prev   = f_s0;
    din0_prev = din0;
  end

  // Runs one frame starting from frame cycle 0.
  // Observation i (1..249) is frame cycle i; i==250 is cycle 0 of the following frame.
  task automatic run_frame(input logic [15:0] word, input int drop_at);
    int   cs_first, cs_last, fs_first, fs_last, sclk_rises, busy_bad, tc_bad;
    logic sclk_prev, fs_at0;
    cs_first = -1; cs_last = -1; fs_first = -1; fs_last = -1;
    sclk_rises = 0; busy_bad = 0; tc_bad = 0; sclk_prev = 1'b0; fs_at0 = 1'bx;
    adc_word = word;
    sb.push_back(word);
    en = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (i == 1) mon_on = 1'b1;
      if (i == drop_at) en = 1'b0;
      if (i < 250) begin
        if (!cs_n0) begin
          if (cs_first < 0) cs_first = i;
          cs_last = i;
        end
        if (f_s0) begin
          if (fs_first < 0) fs_first = i;
          fs_last = i;
        end
      end else begin
        fs_at0 = f_s0;
      end
      if (sclk0 && !sclk_prev) sclk_rises++;
      sclk_prev = sclk0;
      if (busy0 !== ~cs_n0) busy_bad++;
      if ({cs_n1, sclk1, f_s1, busy1} !== {cs_n0, sclk0, f_s0, busy0}) tc_bad++;
    end
    check("cs_first_cycle", cs_first, 1);
    check("cs_last_cycle", cs_last, 65);
    check("sclk_rising_edges", sclk_rises, 16);
    check("fs_first_cycle", fs_first, 125);
    check("fs_last_cycle", fs_last, 249);
    check("fs_low_at_cycle0", {31'b0, fs_at0}, 0);
    check("busy_is_not_cs_n", busy_bad, 0);
    check("instances_lockstep", tc_bad, 0);
  endtask

  initial begin
    int          s;
    int          cs_act, fs_act;
    logic [15:0] w;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'b0, cs_n0}, 1);
    check("rst_sclk", {31'b0, sclk0}, 0);
    check("rst_f_s", {31'b0, f_s0}, 0);
    check("rst_din", din0, 16'h0000);
    check("rst_busy", {31'b0, busy0}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cs_n", {31'b0, cs_n0}, 1);

    // Mid-scale offset-binary code maps to zero.
    run_frame(16'h8000, 0);
    check("din_8000", din0, 16'h0000);

    // Full-scale codes on consecutive frames.
    run_frame(16'hFFFF, 0);
    check("din_ffff", din0, 16'h7FFF);
    run_frame(16'h0000, 0);
    check("din_0000", din0, 16'h8000);
    check("b2b_rise_gap", last_gap, 250);

    // Two's-complement pass-through checks MSB-first bit order.
    run_frame(16'hA5C3, 0);
    check("din_tc_a5c3", din1, 16'hA5C3);
    check("din_ob_a5c3", din0, 16'h25C3);

    // Reset in the middle of the shift of the next frame (en is still high).
    adc_word = 16'h1234;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 30) begin
        mon_on = 1'b0;
        rst    = 1'b0;
      end
    end
    @(negedge clk);
    check("abort_cs_n", {31'b0, cs_n0}, 1);
    check("abort_sclk", {31'b0, sclk0}, 0);
    check("abort_f_s", {31'b0, f_s0}, 0);
    check("abort_din", din0, 16'h0000);
    check("abort_busy", {31'b0, busy0}, 0);
    rst = 1'b1;
    run_frame(16'h0001, 0);
    check("din_after_abort", din0, 16'h8001);

    // en dropped at cycle 10: the frame still completes.
    run_frame(16'h7F00, 10);
    check("din_en_drop", din0, 16'hFF00);
    cs_act = 0;
    fs_act = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cs_n0) cs_act++;
      if (f_s0) fs_act++;
    end
    check("idle_no_cs", cs_act, 0);
    check("idle_no_fs", fs_act, 0);
    run_frame(16'h1357, 0);
    check("din_reenable", din0, 16'h9357);

    // 1020 Hz full-scale sine, back-to-back frames.
    b2b   = 1'b1;
    rises = 0;
    for (int n = 0; n < 100; n++) begin
      s = $rtoi($floor(32767.0 * $sin(2.0 * 3.141592653589793 * 1020.0 * real'(n) / 40000.0) + 0.5));
      w = 16'(s) ^ 16'h8000;
      run_frame(w, 0);
    end
    en  = 1'b0;
    b2b = 1'b0;
    repeat (5) @(negedge clk);
    check("sine_fs_rises", rises, 100);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_frame_src.md
# adc_frame_src

Sample-source front end for the filter chain. Generates the 40 kHz frame strobe `f_s` from the 10 MHz system clock and reads one 16-bit sample per frame from an external serial ADC. It presents the sample on `din` with the timing the IIR filter blocks require. It is the producer end of the `f_s`/`din` interface that the filters consume.

## Interface
- `CLK_DIV`, 250: clk cycles per frame (10 MHz / 40 kHz).
- `FS_RISE`, 125: frame cycle index at which `f_s` rises and `din` updates.
- `SCLK_DIV`, 2: clk cycles per ADC serial-clock half period.
- `DATA_W`, 16: sample width.
- `OFFSET_BIN`, 1: 1 means the ADC word is offset binary and its MSB is inverted; 0 means two's complement, passed through unchanged.
- Legal set: `3 + 2*SCLK_DIV*DATA_W <= FS_RISE <= CLK_DIV-2`.
- `clk  in  1`: system clock, 10 MHz.
- `rst  in  1`: reset, synchronous, active-low.
- `en  in  1`: run enable.
- `adc_sdo  in  1`: ADC serial data, MSB first, changes after sclk falls.
- `adc_cs_n  out  1`: ADC chip select, active-low.
- `adc_sclk  out  1`: ADC serial clock, idles low.
- `f_s  out  1`: frame strobe to the filters.
- `din  out  DATA_W` (signed): sample to the filters.
- `busy  out  1`: high while `adc_cs_n` is low.

## Operation
- Frame counter `c` runs 0..CLK_DIV-1 and wraps to 0. "Cycle c" means the cycle in which the registered outputs show that frame position.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, WAIT.
- IDLE: counter held at 0, `adc_cs_n`=1, `adc_sclk`=0, `f_s`=0, `din` holds its last value. A frame starts at the first edge with `en`=1.
- CS_SETUP, cycle 1: `adc_cs_n`=0, `adc_sclk`=0.
- SHIFT, cycles 2..1+2*SCLK_DIV*DATA_W:
  - Bit k occupies 2*SCLK_DIV cycles: sclk low for the first half, high for the second half.
  - `adc_sdo` is sampled on the edge that ends the high phase and shifted in MSB first.
- CS_HOLD: `adc_cs_n` returns to 1 and the assembled word moves into the pending register.
  - Format conversion: if OFFSET_BIN, pending = {~raw[MSB], raw[MSB-1:0]}; otherwise pending = raw.
- WAIT until cycle FS_RISE:
  - `din` <= pending and `f_s` <= 1 in the same cycle.
  - `f_s` stays 1 through cycle CLK_DIV-1 and returns to 0 at cycle 0 of the next frame.
- `din` is constant for the whole frame apart from that single update.
- `en` low mid-frame: the current frame completes, including its `f_s` pulse, then the block enters IDLE at cycle 0.
- Back-to-back frames with `en` held high: cycle 0 of the next frame follows cycle CLK_DIV-1 directly, with no gap.

## Timing
- Reset (rst=0 at an edge) takes effect on that edge:
  - Outputs: `adc_cs_n`=1, `adc_sclk`=0, `f_s`=0, `din`=0, `busy`=0.
  - Internal: counter 0, state IDLE, pending 0.
- Reset mid-conversion aborts: `adc_cs_n` is high on the cycle after the reset edge, and `din` is 0 (no partial word is ever presented).
- Defaults: `adc_cs_n` low in cycles 1..65, sclk period 4 cycles (2.5 MHz), 16 bits in 64 cycles. Bit k is sampled at the end of cycle 5+4k.
- Latency: last ADC bit sampled at the end of cycle 65, `din` valid from cycle 125 (FS_RISE).
- `f_s` high width is CLK_DIV-FS_RISE = 125 cycles; low width is FS_RISE = 125 cycles. Both are ≥2 cycles, which the filters' edge detectors require.
- `din` is stable for ≥2 cycles before any `f_s` rising-edge consumer samples it.
- `busy` equals ~`adc_cs_n` exactly, cycle for cycle.

## Structure
- The shared package `dsp_pkg` holds:
  - the FSM state enum;
  - `DATA_W_DEF`=16, `CLK_DIV_DEF`=250, `FS_RISE_DEF`=125;
  - the function that checks the legal-set condition. Out-of-range parameters are an elaboration-time error.
- Sub-module `adc_spi_rx` contains the sclk divider, the bit counter and the shift register. It has a start pulse in and a done pulse plus raw word out.
- The top level holds the frame counter, the FSM, format conversion and the `f_s`/`din` registers.

## Test plan
- Reset, then `en`=1 with the ADC model returning 0x8000 (OFFSET_BIN=1) → `din`=0x0000 at cycle 125; `f_s` high in cycles 125..249; `adc_cs_n` low in cycles 1..65; 16 sclk rising edges.
- ADC returns 0xFFFF, then 0x0000 on consecutive frames → `din`=0x7FFF, then 0x8000. Each update lands exactly on an `f_s` rising edge, and the two rising edges are 250 cycles apart.
- OFFSET_BIN=0, ADC returns 0xA5C3 → `din`=0xA5C3. Bit-serial order is checked MSB first.
- `rst`=0 asserted at cycle 30 (mid-shift) → `adc_cs_n`=1, `adc_sclk`=0, `f_s`=0, `din`=0 on the next cycle. After release with `en`=1, a clean frame starts at cycle 0.
- `en` dropped at cycle 10 → the frame completes, the `f_s` pulse occurs, and no further cs activity follows. `en` re-asserted → the next frame starts on the following edge.
- Filter integration: drive a 1020 Hz full-scale sine through the ADC model into the band-pass filter. Require ≥100 frames with no missed or extra `f_s` edges and `din` stable across every `f_s` rising edge ±2 cycles.
